flop_pipe: RTL and testbench
============================

# flop_pipe

Parametrised, elastic multi-stage pipeline register with a valid/ready handshake on both sides. It generalises the plain 8-bit `flop` to configurable data width and stage count, and adds the following:

- per-stage valid tracking with bubble collapse;
- back-pressure;
- synchronous flush;
- an occupancy count.

It sits between any two datapath blocks that need registered, stallable transport, for example between processor pipeline stages or in front of memory interfaces.

## Interface
- `WIDTH`, default 8: data width in bits, ≥1.
- `DEPTH`, default 4: number of register stages, ≥1.
- `RESET_VAL`, default 0: value loaded into every data register on reset.

- `clk` input 1: single clock, rising-edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: upstream presents `in_data`.
- `in_ready` output 1: stage 0 can accept this cycle.
- `in_data` input `WIDTH`: upstream data.
- `out_valid` output 1: last stage holds valid data.
- `out_ready` input 1: downstream accepts this cycle.
- `out_data` output `WIDTH`: data register of the last stage.
- `flush` input 1: synchronous clear of all valid bits.
- `count` output `$clog2(DEPTH+1)`: number of valid stages.

## Operation
- **Stage state.** Stage i (0..DEPTH-1) holds `v[i]` and `d[i]`. Stage DEPTH-1 drives `out_valid` and `out_data`.
- **Ready chain.** `rdy[DEPTH] = out_ready` and `rdy[i] = !v[i] | rdy[i+1]`. This chain is combinational and gives full throughput with bubble collapse.
- **`in_ready`.** Equals `rdy[0]`, gated as described under flush and reset.
- **Transfers.** An upstream transfer occurs when `in_valid & in_ready`. A downstream transfer occurs when `out_valid & out_ready`.
- **Per-stage update.** At each edge where `rdy[i]` is 1:
  - `v[i] <= v[i-1]`, where `v[-1] = in_valid`.
  - `d[i] <= d[i-1]` only when `v[i-1]`, where `d[-1] = in_data`. Otherwise `d[i]` holds.
- **Stalled stage.** A stage with `rdy[i] = 0` holds both `v[i]` and `d[i]`.
- **Data while invalid.** Data registers never change while their incoming valid is 0. `out_data` is therefore stable but meaningless while `out_valid = 0`.
- **`count`.** Popcount of `v[]`, combinational from registers. Range 0..DEPTH.
- **Flush.** `flush = 1` during a cycle has these effects:
  - `in_ready` and `out_valid` are forced to 0, so no transfer occurs.
  - At the edge, all `v[]` are cleared and `d[]` holds.
  - The next cycle shows `count = 0` and `in_ready = 1`.
- **Reset.** While `rst_n = 0`:
  - all `v = 0` and all `d = RESET_VAL`;
  - `in_ready = 0`, `out_valid = 0`, `out_data = RESET_VAL`, `count = 0`.
- **Reset mid-operation.** Contents are discarded immediately (asynchronously).
- **First cycle after reset release.** `in_ready = 1`.
- **Ordering.** Data leave in arrival order. There is no duplication or loss except by flush or reset.

## Timing
- **Latency.** On an empty pipe with `out_ready` held at 1, data accepted at edge n appear with `out_valid = 1` after edge n+DEPTH-1. That is DEPTH register stages, counting the accepting edge as stage 0.
- **Throughput.** One item per cycle while `out_ready = 1`.
- **Capacity.** DEPTH items. With `out_ready = 0`, `in_ready` falls after DEPTH accepts.
- **Full pipe.** Simultaneous accept and emit is allowed; `count` is unchanged.
- **Bubble collapse.** A valid item advances into any empty stage ahead of it every cycle, independent of `out_ready`.
- **`out_ready` is a valid input to `in_ready`.** A combinational path exists from `out_ready` to `in_ready`, depth O(DEPTH). It is acceptable for DEPTH ≤ 8. Larger depths need an external skid buffer.
- **Handshake rules.** Once asserted, upstream holds `in_valid` and `in_data` until accepted; the block does not check this. `out_valid` never deasserts without a downstream transfer, except on flush or reset.

## Structure
- **Shared package `flop_pkg`:**
  - default `WIDTH` and `DEPTH` constants;
  - the `count` width function (`$clog2(DEPTH+1)`);
  - the `RESET_VAL` default.
- **Sub-module `flop_stage`:** one valid/data register slice. Inputs are `clk`, `rst_n`, `flush`, incoming valid/data and downstream ready. Outputs are valid, data and this slice's ready. `flop_pipe` instantiates DEPTH of them with a generate loop and computes `count`.

## Test plan
- **Reset.** Assert `rst_n = 0` mid-stream with 3 items in flight. Required: `out_valid = 0`, `in_ready = 0`, `count = 0` and `out_data = RESET_VAL` immediately. After release: `in_ready = 1`, and no stale item ever emerges.
- **Streaming, default parameters.** `WIDTH = 8`, `DEPTH = 4`, `out_ready = 1`. Send 0x44, 0x33, 0xFF, 0x66 on consecutive edges. Required: outputs appear in order, first at edge n+3, one per cycle, with `count` peaking at 4.
- **Back-pressure.** `out_ready = 0`; offer 6 items. Required: exactly 4 accepted, `in_ready = 0` with `count = 4`. Then raise `out_ready`: 0x44, 0x33, 0xFF, 0x66 drain in order, and items 5 and 6 follow with no gap.
- **Bubble collapse.** Insert 0xAA, an idle cycle, then 0xBB, with `out_ready = 0` until `count = 2`. Required: 0xAA sits in stage 3 and 0xBB in stage 2 (adjacent), and `in_ready = 1`.
- **Flush.** With 3 items valid, pulse `flush` for 1 cycle while `in_valid = 1`. Required: no accept in the flush cycle, `out_valid = 0` in that cycle, and `count = 0` the next cycle. A following item 0x5A exits after DEPTH cycles.
- **Parameter sweep.** `WIDTH = 32`, `DEPTH = 1` and `WIDTH = 1`, `DEPTH = 8`, random valid/ready with a scoreboard. Required: zero mismatches over 10k cycles, and `count` never exceeds DEPTH.

Source files
------------

// File: rtl/flop_pkg.sv
`default_nettype none
// ============================================================================
// Module      : flop_pkg
// Description : Shared defaults and helpers for the elastic pipeline register
//               (flop_pipe / flop_stage).
// Revision    : 1.0 - initial release
// ============================================================================
package flop_pkg;

    // Default data width of one pipeline slot, in bits.
    localparam int DEFAULT_WIDTH     = 8;

    // Default number of register stages.
    localparam int DEFAULT_DEPTH     = 4;

    // Default value loaded into every data register while reset is held.
    localparam int DEFAULT_RESET_VAL = 0;

    // Width of the occupancy counter: it must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage : flop_pkg
`default_nettype wire

// File: rtl/flop_stage.sv
`default_nettype none
// ============================================================================
// Module      : flop_stage
// Description : One valid/data slice of the elastic pipeline. The slice
//               accepts new contents whenever it is empty or the slice ahead
//               of it is moving, which gives bubble collapse and full
//               throughput. Data only loads when the incoming valid is set.
// Revision    : 1.0 - initial release
// ============================================================================
module flop_stage
    import flop_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEFAULT_RESET_VAL)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    input  logic             next_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             ready
);

    // This slice can take new contents when it is empty or its occupant
    // moves on at this edge.
    assign ready = ~valid | next_ready;

    // Valid/data register: flush clears only the valid bit, and data is
    // captured only alongside a valid item so it never churns on bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= RESET_VAL;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (ready) begin
            valid <= prev_valid;
            if (prev_valid) begin
                data <= prev_data;
            end
        end
    end

endmodule : flop_stage
`default_nettype wire

// File: rtl/flop_pipe.sv
`default_nettype none
// ============================================================================
// Module      : flop_pipe
// Description : Parametrised elastic multi-stage pipeline register with a
//               valid/ready handshake on both sides, bubble collapse,
//               back-pressure, synchronous flush and an occupancy count.
//               Stage DEPTH-1 is the output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module flop_pipe
    import flop_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter int               DEPTH     = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEFAULT_RESET_VAL)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    input  logic                          flush,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int COUNT_W = count_width(DEPTH);

    // rdy[i] is the ready of stage i; rdy[DEPTH] is the downstream ready.
    // The chain is purely combinational so a stall at the output ripples
    // back to the input in the same cycle.
    logic [DEPTH:0]   rdy;
    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];

    assign rdy[DEPTH] = out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             stage_in_valid;
        logic [WIDTH-1:0] stage_in_data;

        if (i == 0) begin : g_head
            // The first stage is fed straight from the upstream interface.
            assign stage_in_valid = in_valid;
            assign stage_in_data  = in_data;
        end else begin : g_body
            assign stage_in_valid = v[i-1];
            assign stage_in_data  = d[i-1];
        end

        flop_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .flush      (flush),
            .prev_valid (stage_in_valid),
            .prev_data  (stage_in_data),
            .next_ready (rdy[i+1]),
            .valid      (v[i]),
            .data       (d[i]),
            .ready      (rdy[i])
        );
    end

    // Upstream ready is suppressed during flush (the flush edge would throw
    // the item away) and while reset is held, so nothing is lost silently.
    assign in_ready  = rdy[0] & ~flush & rst_n;

    // A flush cycle must not hand out an item that is about to be cleared.
    assign out_valid = v[DEPTH-1] & ~flush;
    assign out_data  = d[DEPTH-1];

    // Occupancy: population count of the stage valid bits.
    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count = count + COUNT_W'(v[i]);
        end
    end

endmodule : flop_pipe
`default_nettype wire

// File: tb/tb_flop_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_flop_pipe
// Description : Self-checking bench for flop_pipe: directed reset, streaming,
//               back-pressure, bubble-collapse, flush and reset-in-flight
//               sequences on the default configuration, followed by a random
//               scoreboard run on WIDTH=32/DEPTH=1 and WIDTH=1/DEPTH=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flop_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Default configuration instance (WIDTH 8, DEPTH 4).
    logic       iv0, ir0, ov0, ordy0, fl0;
    logic [7:0] id0, od0;
    logic [2:0] cnt0;

    // WIDTH 32, DEPTH 1.
    logic        iv1, ir1, ov1, ordy1, fl1;
    logic [31:0] id1, od1;
    logic [0:0]  cnt1;

    // WIDTH 1, DEPTH 8.
    logic       iv2, ir2, ov2, ordy2, fl2;
    logic [0:0] id2, od2;
    logic [3:0] cnt2;

    flop_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
        .out_valid(ov0), .out_ready(ordy0), .out_data(od0), .flush(fl0), .count(cnt0)
    );

    flop_pipe #(.WIDTH(32), .DEPTH(1), .RESET_VAL(32'hDEADBEEF)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(ordy1), .out_data(od1), .flush(fl1), .count(cnt1)
    );

    flop_pipe #(.WIDTH(1), .DEPTH(8), .RESET_VAL(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
        .out_valid(ov2), .out_ready(ordy2), .out_data(od2), .flush(fl2), .count(cnt2)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0]  items [6] = '{8'h44, 8'h33, 8'hFF, 8'h66, 8'h77, 8'h88};
    logic [31:0] q1 [$];
    logic        q2 [$];
    logic        took1, took2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Hard stop if the run ever overruns its schedule.
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        iv0 = 0; id0 = '0; ordy0 = 0; fl0 = 0;
        iv1 = 0; id1 = '0; ordy1 = 0; fl1 = 0;
        iv2 = 0; id2 = '0; ordy2 = 0; fl2 = 0;
        took1 = 0; took2 = 0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        settle();
        chk("rst_in_ready",  ir0, 0);
        chk("rst_out_valid", ov0, 0);
        chk("rst_count",     cnt0, 0);
        chk("rst_out_data",  od0, 8'hA5);
        chk("rst_out_data32", od1, 32'hDEADBEEF);
        chk("rst_out_data1",  od2, 1'b1);

        #2 rst_n = 1'b1;
        settle();
        chk("rel_in_ready",  ir0, 1);
        chk("rel_count",     cnt0, 0);
        chk("rel_out_valid", ov0, 0);

        // ---------------- streaming ----------------
        ordy0 = 1;
        for (int k = 0; k < 4; k++) begin
            iv0 = 1; id0 = items[k];
            settle();
            chk("stream_in_ready", ir0, 1);
            tick();
            if (k < 3) begin
                chk("stream_latency", ov0, 0);
            end else begin
                chk("stream_first_valid", ov0, 1);
                chk("stream_first_data",  od0, 8'h44);
                chk("stream_count_peak",  cnt0, 4);
            end
        end
        iv0 = 0;
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("stream_valid", ov0, 1);
            chk("stream_data",  od0, items[k]);
        end
        tick();
        chk("stream_done_valid", ov0, 0);
        chk("stream_done_count", cnt0, 0);

        // ---------------- back-pressure ----------------
        ordy0 = 0;
        for (int k = 0; k < 4; k++) begin
            iv0 = 1; id0 = items[k];
            settle();
            chk("bp_accept", ir0, 1);
            tick();
        end
        iv0 = 1; id0 = items[4];
        settle();
        chk("bp_full_ready", ir0, 0);
        chk("bp_full_count", cnt0, 4);
        chk("bp_full_valid", ov0, 1);
        chk("bp_full_data",  od0, 8'h44);
        tick();
        settle();
        chk("bp_hold_ready", ir0, 0);
        chk("bp_hold_count", cnt0, 4);
        ordy0 = 1;
        settle();
        chk("bp_release_ready", ir0, 1);
        tick();
        chk("bp_drain_valid", ov0, 1);
        chk("bp_drain_data",  od0, 8'h33);
        id0 = items[5];
        settle();
        chk("bp_item6_ready", ir0, 1);
        tick();
        chk("bp_drain_valid", ov0, 1);
        chk("bp_drain_data",  od0, 8'hFF);
        iv0 = 0;
        for (int k = 3; k < 6; k++) begin
            tick();
            chk("bp_drain_valid", ov0, 1);
            chk("bp_drain_data",  od0, items[k]);
        end
        tick();
        chk("bp_empty_valid", ov0, 0);
        chk("bp_empty_count", cnt0, 0);

        // ---------------- bubble collapse ----------------
        ordy0 = 0;
        iv0 = 1; id0 = 8'hAA; tick();
        iv0 = 0; tick();
        iv0 = 1; id0 = 8'hBB; tick();
        iv0 = 0; tick(); tick();
        settle();
        chk("bub_count",    cnt0, 2);
        chk("bub_valid",    ov0, 1);
        chk("bub_head",     od0, 8'hAA);
        chk("bub_in_ready", ir0, 1);
        ordy0 = 1;
        tick();
        chk("bub_adjacent_valid", ov0, 1);
        chk("bub_adjacent_data",  od0, 8'hBB);
        tick();
        chk("bub_empty_valid", ov0, 0);
        chk("bub_empty_count", cnt0, 0);

        // ---------------- flush ----------------
        ordy0 = 0;
        for (int k = 0; k < 3; k++) begin
            iv0 = 1; id0 = items[k];
            tick();
        end
        iv0 = 0;
        tick();
        settle();
        chk("fl_pre_count", cnt0, 3);
        chk("fl_pre_valid", ov0, 1);
        fl0 = 1; iv0 = 1; id0 = 8'h99; ordy0 = 1;
        settle();
        chk("fl_in_ready",  ir0, 0);
        chk("fl_out_valid", ov0, 0);
        chk("fl_count",     cnt0, 3);
        tick();
        fl0 = 0; id0 = 8'h5A;
        settle();
        chk("fl_after_count",    cnt0, 0);
        chk("fl_after_in_ready", ir0, 1);
        chk("fl_after_valid",    ov0, 0);
        tick();
        iv0 = 0;
        for (int k = 0; k < 3; k++) begin
            chk("fl_5a_latency", ov0, 0);
            tick();
        end
        chk("fl_5a_valid", ov0, 1);
        chk("fl_5a_data",  od0, 8'h5A);
        tick();
        chk("fl_end_valid", ov0, 0);
        chk("fl_end_count", cnt0, 0);

        // ---------------- reset mid-stream ----------------
        ordy0 = 0;
        for (int k = 0; k < 3; k++) begin
            iv0 = 1; id0 = 8'(k + 1);
            tick();
        end
        iv0 = 0;
        tick();
        settle();
        chk("rmid_pre_count", cnt0, 3);
        chk("rmid_pre_valid", ov0, 1);
        chk("rmid_pre_data",  od0, 8'h01);
        rst_n = 1'b0;
        #1;
        chk("rmid_out_valid", ov0, 0);
        chk("rmid_in_ready",  ir0, 0);
        chk("rmid_count",     cnt0, 0);
        chk("rmid_out_data",  od0, 8'hA5);
        tick();
        rst_n = 1'b1;
        settle();
        chk("rmid_rel_ready", ir0, 1);
        chk("rmid_rel_count", cnt0, 0);
        ordy0 = 1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rmid_no_stale", ov0, 0);
        end

        // ---------------- random parameter sweep ----------------
        for (int c = 0; c < 10000; c++) begin
            if (!iv1 || took1) begin
                iv1 = 1'($urandom_range(0, 1));
                id1 = $urandom;
            end
            if (!iv2 || took2) begin
                iv2 = 1'($urandom_range(0, 1));
                id2 = 1'($urandom);
            end
            ordy1 = ($urandom_range(0, 3) != 0);
            ordy2 = ($urandom_range(0, 3) == 0);
            fl1   = ($urandom_range(0, 63) == 0);
            fl2   = ($urandom_range(0, 63) == 0);
            settle();

            chk("sw1_count",    cnt1, q1.size());
            chk("sw1_in_ready", ir1, !fl1 && (q1.size() < 1 || ordy1));
            if (fl1) chk("sw1_flush_valid", ov1, 0);
            if (ov1 && ordy1) begin
                if (q1.size() == 0) chk("sw1_spurious", ov1, 0);
                else                chk("sw1_data", od1, q1.pop_front());
            end
            took1 = iv1 && ir1;
            if (took1) q1.push_back(id1);
            if (fl1) q1.delete();

            chk("sw2_count",    cnt2, q2.size());
            chk("sw2_count_max", (cnt2 > 8), 0);
            chk("sw2_in_ready", ir2, !fl2 && (q2.size() < 8 || ordy2));
            if (fl2) chk("sw2_flush_valid", ov2, 0);
            if (ov2 && ordy2) begin
                if (q2.size() == 0) chk("sw2_spurious", ov2, 0);
                else                chk("sw2_data", od2, q2.pop_front());
            end
            took2 = iv2 && ir2;
            if (took2) q2.push_back(id2);
            if (fl2) q2.delete();

            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_flop_pipe
`default_nettype wire
